alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Parametrised successor to the combinational ALU-control decode. Decodes ALUControl/Opcode into an ALU operation.
//  Executes single-cycle ops in one clock and multi-cycle ops (variable shift, shift-add multiply) iteratively.
//  Sits between the control FSM and the register-file writeback. The control FSM stalls on busy and writes back on done.
// PARAMETERS
//  WIDTH    16                  datapath width of A, B and result
//  SHAMT_W  $clog2(WIDTH) (4)   shift-amount field width, taken from B[SHAMT_W-1:0]
//  MUL_EN   1                   1 = multiply supported; 0 = MUL executes as ADD, single cycle
// PORTS
//  CLK         in   1      clock, rising edge
//  Reset       in   1      synchronous, active-high
//  start       in   1      request; accepted only when busy=0
//  ALUControl  in   2      00 add, 01 sub, 10 use Opcode, 11 pass A
//  Opcode      in   4      instruction opcode; used only when ALUControl=10
//  A           in   WIDTH  operand A
//  B           in   WIDTH  operand B / shift amount
//  result      out  WIDTH  registered result, held until next accepted start
//  zero        out  1      registered (result==0), updated with result
//  busy        out  1      1 from the cycle after acceptance until done
//  done        out  1      one-cycle pulse, coincident with new result
// BEHAVIOUR
//  Op decode, {ext,op3}:
//   ALUControl 00 -> ADD, 01 -> SUB, 11 -> PASSA.
//   ALUControl 10 -> Opcode[3]=0: op3=Opcode[2:0].
//   Single-cycle op3 codes: 000 AND, 001 OR, 010 ADD, 011 PASSA, 110 SUB, 111 SLT (signed, result 0/1).
//   Unlisted op3 codes (100, 101) -> result 0.
//   ALUControl 10 with Opcode[3]=1 -> extended op Opcode[2:0]:
//    000 SLL, 001 SRL (logical), 010 MUL (low WIDTH bits). Others -> result 0, single cycle.
//  Operands A, B and the decoded op are latched at acceptance. Inputs may change afterwards.
//  FSM: IDLE -> RUN -> FIN -> IDLE.
//   IDLE: start=1 with a single-cycle op -> FIN; result computed into the register this edge.
//   IDLE: start=1 with SLL/SRL and shamt>0 -> RUN, cnt=shamt.
//   IDLE: start=1 with MUL (MUL_EN=1) -> RUN, cnt=WIDTH.
//   SLL/SRL with shamt=0 -> FIN directly, result = A.
//   RUN: each cycle shift one bit (shift), or add-if-B[0] then shift (MUL); cnt-=1.
//   RUN: cnt reaching 0 -> FIN.
//   FIN: done=1 for one cycle, busy=0, -> IDLE. start in FIN is ignored.
//  Latency, start at edge t:
//   single-cycle -> done at t+1.
//   shift by n>0 -> done at t+1+n.
//   MUL -> done at t+1+WIDTH.
//  busy: 1 in RUN only. start while busy is ignored; no queuing.
//  Arithmetic is modulo 2^WIDTH. Carry/overflow are discarded. Shifts by >= WIDTH yield 0.
//  Reset, including mid-operation: state=IDLE, cnt=0, result=0, zero=1, busy=0, done=0.
//   An in-flight op is abandoned with no done pulse.
//  Reset and start in the same cycle: Reset wins; start is dropped.
// STRUCTURE
//  Package alu_seq_pkg: ALUControl encodings, op3/extended op constants, FSM state encoding.
//  Sub-module alu_core: purely combinational single-cycle unit (op3, A, B -> y).
//   Reused for the ADD step of MUL.
//  Top: decode, operand/op latches, counter, FSM, result/zero registers.
// TESTING
//  1. ALUControl=00, A=0x0005, B=0x0003, start -> done at t+1, result=0x0008, zero=0.
//  2. ALUControl=01, A=B=0x1234 -> result=0x0000, zero=1.
//     ALUControl=10, Opcode=0111, A=0xFFFF, B=0x0001 -> result=0x0001 (signed SLT).
//  3. Opcode=1000 SLL, A=0x0001, B=0x0004 -> busy 4 cycles, done at t+5, result=0x0010.
//     B=0x0000 -> done at t+1, result=0x0001.
//  4. Opcode=1010 MUL, A=0x0003, B=0x0007 -> done at t+17, result=0x0015.
//     A=0x8000, B=0x0002 -> result=0x0000 (wrap).
//  5. start pulsed every cycle during a MUL -> exactly one done. Result unchanged until that done.
//  6. Reset asserted at cycle 5 of a MUL -> next edge idle, result=0, zero=1, no done.
//     Reset+start in the same cycle -> start dropped.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU op sequencer: control codes, op codes and FSM states.
// The decode helper maps ALUControl/Opcode onto a single {ext, op3} pair.
package alu_seq_pkg;

    localparam logic [1:0] CTL_ADD  = 2'b00;
    localparam logic [1:0] CTL_SUB  = 2'b01;
    localparam logic [1:0] CTL_OPC  = 2'b10;
    localparam logic [1:0] CTL_PASS = 2'b11;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    localparam logic [2:0] EXT_SLL  = 3'b000;
    localparam logic [2:0] EXT_SRL  = 3'b001;
    localparam logic [2:0] EXT_MUL  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    typedef struct packed {
        logic       ext;
        logic [2:0] op3;
    } op_t;

    function automatic op_t op_decode(input logic [1:0] ctl, input logic [3:0] opc);
        op_t d;
        d.ext = 1'b0;
        d.op3 = OP_PASSA;
        case (ctl)
            CTL_ADD: d.op3 = OP_ADD;
            CTL_SUB: d.op3 = OP_SUB;
            CTL_OPC: begin
                d.ext = opc[3];
                d.op3 = opc[2:0];
            end
            default: d.op3 = OP_PASSA;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between the control FSM and the ALU op sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       ALUControl;
    logic [3:0]       Opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUControl, Opcode, A, B,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, ALUControl, Opcode, A, B,
        output result, zero, busy, done
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational single-cycle ALU; also supplies the accumulate step of multiply.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;

    assign sa = a;
    assign sb = b;

    always_comb begin
        y = '0;
        case (op3)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_ADD:   y = a + b;
            OP_PASSA: y = a;
            OP_SUB:   y = a - b;
            OP_SLT:   y = {{(WIDTH-1){1'b0}}, (sa < sb)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: single-cycle ops finish in one clock, shifts and multiply iterate
// one bit per clock in RUN. The result register only changes when an op completes.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int MUL_EN  = 1
) (
    input  logic          CLK,
    input  logic          Reset,
    alu_op_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    op_t              op_in;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0] result;
    logic             zero;

    logic             start_run;
    logic             run_mul;
    logic             load_res;
    logic [WIDTH-1:0] res_next;

    logic [2:0]       core_op;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [WIDTH-1:0] core_y;

    assign op_in = op_decode(bus.ALUControl, bus.Opcode);
    assign shamt = bus.B[SHAMT_W-1:0];

    // While iterating, the core is borrowed as the multiply accumulator adder.
    always_comb begin
        core_op = op_in.op3;
        core_a  = bus.A;
        core_b  = bus.B;
        if (state == ST_RUN) begin
            core_op = OP_ADD;
            core_a  = acc;
            core_b  = mcand;
        end else if (op_in.ext && op_in.op3 == EXT_MUL) begin
            core_op = OP_ADD;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op3 (core_op),
        .a   (core_a),
        .b   (core_b),
        .y   (core_y)
    );

    always_comb begin
        acc_next = acc;
        case (op_q)
            EXT_SLL: acc_next = acc << 1;
            EXT_SRL: acc_next = acc >> 1;
            default: acc_next = mplier[0] ? core_y : acc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        run_mul    = 1'b0;
        load_res   = 1'b0;
        res_next   = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_FIN;
                    load_res   = 1'b1;
                    if (!op_in.ext) begin
                        res_next = core_y;
                    end else begin
                        case (op_in.op3)
                            EXT_SLL, EXT_SRL: begin
                                if (shamt == '0) begin
                                    res_next = bus.A;
                                end else begin
                                    load_res   = 1'b0;
                                    start_run  = 1'b1;
                                    state_next = ST_RUN;
                                end
                            end
                            EXT_MUL: begin
                                if (MUL_EN != 0) begin
                                    load_res   = 1'b0;
                                    start_run  = 1'b1;
                                    run_mul    = 1'b1;
                                    state_next = ST_RUN;
                                end else begin
                                    res_next = core_y;
                                end
                            end
                            default: res_next = '0;
                        endcase
                    end
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    load_res   = 1'b1;
                    res_next   = acc_next;
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Control and visible result registers; cleared by reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            if (start_run) begin
                cnt <= run_mul ? CNT_W'(WIDTH) : CNT_W'(shamt);
            end else if (state == ST_RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (load_res) begin
                result <= res_next;
                zero   <= (res_next == '0);
            end
        end
    end

    // Working operands; always reloaded at acceptance, so no reset needed.
    always_ff @(posedge CLK) begin
        if (start_run) begin
            op_q   <= op_in.op3;
            acc    <= run_mul ? '0 : bus.A;
            mcand  <= bus.A;
            mplier <= bus.B;
        end else if (state == ST_RUN) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    assign bus.result = result;
    assign bus.zero   = zero;
    assign bus.busy   = (state == ST_RUN);
    assign bus.done   = (state == ST_FIN);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: decode, latency, busy/done handshake and reset behaviour.
module tb_alu_op_sequencer;

    logic CLK = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    alu_op_sequencer_if #(.WIDTH(16)) bus ();

    alu_op_sequencer #(.WIDTH(16), .SHAMT_W(4), .MUL_EN(1)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] ctl, input logic [3:0] opc,
                         input logic [15:0] a, input logic [15:0] b);
        bus.ALUControl = ctl;
        bus.Opcode     = opc;
        bus.A          = a;
        bus.B          = b;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 1;
        busy_cyc = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cyc++;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] ctl, input logic [3:0] opc,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input int exp_lat);
        int lat;
        int bc;
        issue(ctl, opc, a, b);
        wait_done(lat, bc);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, bc, exp_lat - 1);
        check({tag, " result"}, bus.result, exp_res);
        check({tag, " zero"}, bus.zero, (exp_res == 16'h0));
        tick();
        check({tag, " done pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int lat;
        int bc;
        int dones;
        logic stable;

        Reset = 1'b1;
        bus.start = 1'b0;
        bus.ALUControl = 2'b00;
        bus.Opcode = 4'h0;
        bus.A = 16'h0;
        bus.B = 16'h0;
        tick();
        tick();
        Reset = 1'b0;
        check("reset result", bus.result, 16'h0);
        check("reset zero", bus.zero, 1'b1);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);

        run_op("add", 2'b00, 4'h0, 16'h0005, 16'h0003, 16'h0008, 1);
        run_op("sub", 2'b01, 4'h0, 16'h1234, 16'h1234, 16'h0000, 1);
        run_op("slt neg", 2'b10, 4'b0111, 16'hFFFF, 16'h0001, 16'h0001, 1);
        run_op("slt pos", 2'b10, 4'b0111, 16'h0001, 16'hFFFF, 16'h0000, 1);
        run_op("and", 2'b10, 4'b0000, 16'hF0F0, 16'hFF00, 16'hF000, 1);
        run_op("or", 2'b10, 4'b0001, 16'hF0F0, 16'hFF00, 16'hFFF0, 1);
        run_op("op3 100", 2'b10, 4'b0100, 16'h1234, 16'h4321, 16'h0000, 1);
        run_op("pass a", 2'b11, 4'h0, 16'hABCD, 16'h1111, 16'hABCD, 1);
        run_op("add wrap", 2'b00, 4'h0, 16'hFFFF, 16'h0002, 16'h0001, 1);

        run_op("sll 4", 2'b10, 4'b1000, 16'h0001, 16'h0004, 16'h0010, 5);
        run_op("sll 0", 2'b10, 4'b1000, 16'h0001, 16'h0000, 16'h0001, 1);
        run_op("srl 15", 2'b10, 4'b1001, 16'h8000, 16'h000F, 16'h0001, 16);
        run_op("srl 3 hi", 2'b10, 4'b1001, 16'h0080, 16'h0013, 16'h0010, 4);
        run_op("ext 011", 2'b10, 4'b1011, 16'h1234, 16'h0003, 16'h0000, 1);

        run_op("mul 3x7", 2'b10, 4'b1010, 16'h0003, 16'h0007, 16'h0015, 17);
        run_op("mul wrap", 2'b10, 4'b1010, 16'h8000, 16'h0002, 16'h0000, 17);
        run_op("mul 1234x10", 2'b10, 4'b1010, 16'h1234, 16'h0010, 16'h2340, 17);

        // Load a known result, then hammer start during a multiply.
        run_op("pre mul", 2'b00, 4'h0, 16'h0010, 16'h0005, 16'h0015, 1);
        bus.ALUControl = 2'b10;
        bus.Opcode = 4'b1010;
        bus.A = 16'h0005;
        bus.B = 16'h0006;
        bus.start = 1'b1;
        tick();
        bus.ALUControl = 2'b00;
        lat = 1;
        stable = 1'b1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.result !== 16'h0015) stable = 1'b0;
            bus.A = bus.A + 16'h0101;
            bus.B = bus.B + 16'h0003;
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check("hammer stable", stable, 1'b1);
        check("hammer latency", lat, 17);
        check("hammer result", bus.result, 16'h001E);
        dones = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        check("hammer dones", dones, 1);

        issue(2'b10, 4'b1010, 16'h0003, 16'h0007);
        for (int i = 0; i < 4; i++) tick();
        check("pre-reset busy", bus.busy, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid reset busy", bus.busy, 1'b0);
        check("mid reset done", bus.done, 1'b0);
        check("mid reset result", bus.result, 16'h0);
        check("mid reset zero", bus.zero, 1'b1);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        check("abandoned done", dones, 0);

        bus.ALUControl = 2'b00;
        bus.A = 16'h0001;
        bus.B = 16'h0001;
        bus.start = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.start = 1'b0;
        check("rst+start done", bus.done, 1'b0);
        check("rst+start result", bus.result, 16'h0);
        tick();
        check("rst+start later done", bus.done, 1'b0);
        check("rst+start later busy", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
